// File: rtl/legv8_pkg.sv
// Shared LEGv8 encoding definitions: op codes, opcode fields, immediate ranges and error codes.
package legv8_pkg;

    typedef enum logic [3:0] {
        OpAdds = 4'd0,
        OpSubs = 4'd1,
        OpBr   = 4'd2,
        OpLdur = 4'd3,
        OpStur = 4'd4,
        OpAddi = 4'd5,
        OpCbz  = 4'd6,
        OpBlt  = 4'd7,
        OpB    = 4'd8,
        OpBl   = 4'd9
    } op_e;

    localparam logic [10:0] OPC_ADDS = 11'b10101011000;
    localparam logic [10:0] OPC_SUBS = 11'b11101011000;
    localparam logic [10:0] OPC_BR   = 11'b11010110000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [7:0]  OPC_BCND = 8'b01010100;
    localparam logic [5:0]  OPC_B    = 6'b000101;
    localparam logic [5:0]  OPC_BL   = 6'b100101;

    localparam logic [4:0] COND_LT = 5'b01011;

    localparam int IMM9_MIN  = -256;
    localparam int IMM9_MAX  = 255;
    localparam int IMM12_MIN = 0;
    localparam int IMM12_MAX = 4095;
    localparam int IMM19_MIN = -(1 << 18);
    localparam int IMM19_MAX = (1 << 18) - 1;
    localparam int IMM26_MIN = -(1 << 25);
    localparam int IMM26_MAX = (1 << 25) - 1;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_BAD_OP    = 2'd1;
    localparam logic [1:0] ERR_IMM_RANGE = 2'd2;

    function automatic logic imm_in_range(input int value, input int lo, input int hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/legv8_instr_encode.sv
// Combinational LEGv8 encoder: symbolic (op, registers, immediate) to 32-bit word plus error code.
module legv8_instr_encode
    import legv8_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic [1:0]  err_code
);

    int imm_s;
    assign imm_s = int'(imm);

    always_comb begin
        word     = '0;
        err_code = ERR_NONE;
        case (op)
            OpAdds: word = {OPC_ADDS, rm, 6'd0, rn, rd};
            OpSubs: word = {OPC_SUBS, rm, 6'd0, rn, rd};
            // BR repeats Rn in the Rd slot so the decoder sees a consistent register.
            OpBr:   word = {OPC_BR, 5'b11111, 6'd0, rn, rn};
            OpLdur: begin
                if (imm_in_range(imm_s, IMM9_MIN, IMM9_MAX)) begin
                    word = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
                end else begin
                    err_code = ERR_IMM_RANGE;
                end
            end
            OpStur: begin
                if (imm_in_range(imm_s, IMM9_MIN, IMM9_MAX)) begin
                    word = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
                end else begin
                    err_code = ERR_IMM_RANGE;
                end
            end
            OpAddi: begin
                if (imm_in_range(imm_s, IMM12_MIN, IMM12_MAX)) begin
                    word = {OPC_ADDI, imm[11:0], rn, rd};
                end else begin
                    err_code = ERR_IMM_RANGE;
                end
            end
            OpCbz: begin
                if (imm_in_range(imm_s, IMM19_MIN, IMM19_MAX)) begin
                    word = {OPC_CBZ, imm[18:0], rd};
                end else begin
                    err_code = ERR_IMM_RANGE;
                end
            end
            OpBlt: begin
                if (imm_in_range(imm_s, IMM19_MIN, IMM19_MAX)) begin
                    word = {OPC_BCND, imm[18:0], COND_LT};
                end else begin
                    err_code = ERR_IMM_RANGE;
                end
            end
            OpB: begin
                if (imm_in_range(imm_s, IMM26_MIN, IMM26_MAX)) begin
                    word = {OPC_B, imm[25:0]};
                end else begin
                    err_code = ERR_IMM_RANGE;
                end
            end
            OpBl: begin
                if (imm_in_range(imm_s, IMM26_MIN, IMM26_MAX)) begin
                    word = {OPC_BL, imm[25:0]};
                end else begin
                    err_code = ERR_IMM_RANGE;
                end
            end
            default: err_code = ERR_BAD_OP;
        endcase
    end

endmodule

// File: rtl/legv8_instr_writer.sv
// Streaming LEGv8 program loader: encodes accepted requests and writes them to imem from address 0
// through a 2-entry FIFO.
module legv8_instr_writer
    import legv8_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rn,
    input  logic [4:0]        req_rm,
    input  logic [31:0]       req_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic              done,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    localparam logic [ADDR_W+1:0] CAPACITY = {2'b01, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic [31:0]       fifo_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   word_count_q;
    logic              err_valid_q, done_q;
    logic [1:0]        err_code_q;

    logic [31:0]       enc_word;
    logic [1:0]        enc_err;
    logic [ADDR_W+1:0] committed;
    logic              accept, push, pop, start_prog;

    legv8_instr_encode u_encode (
        .op       (req_op),
        .rd       (req_rd),
        .rn       (req_rn),
        .rm       (req_rm),
        .imm      (req_imm),
        .word     (enc_word),
        .err_code (enc_err)
    );

    // Words already written plus words still queued; bounds what may still be accepted.
    assign committed  = {1'b0, word_count_q} + {{ADDR_W{1'b0}}, count_q};
    assign req_ready  = (state_q == StRun) && (count_q != 2'd2) && (committed < CAPACITY);
    assign accept     = req_valid && req_ready;
    assign push       = accept && (enc_err == ERR_NONE);
    assign pop        = imem_we && imem_ready;
    assign start_prog = start && ((state_q == StIdle) || (state_q == StDone));

    // Gated by rst_n so a reset request stops memory writes immediately.
    assign imem_we    = rst_n && (count_q != 2'd0);
    assign imem_addr  = addr_q;
    assign imem_wdata = fifo_q[rd_ptr_q];
    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;
    assign done       = done_q;
    assign word_count = word_count_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: if (start) state_d = StRun;
            StRun:          if (finish) state_d = StDrain;
            StDrain:        if (count_q == 2'd0) state_d = StDone;
            default:        state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            fifo_q[0]    <= '0;
            fifo_q[1]    <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            addr_q       <= '0;
            word_count_q <= '0;
            err_valid_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
            done_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= enc_word;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
            if (start_prog) begin
                addr_q       <= '0;
                word_count_q <= '0;
            end else if (pop) begin
                word_count_q <= word_count_q + 1'b1;
                // Saturate rather than wrap after the last word of a full memory.
                if (addr_q != {ADDR_W{1'b1}}) begin
                    addr_q <= addr_q + 1'b1;
                end
            end
            err_valid_q <= accept && (enc_err != ERR_NONE);
            err_code_q  <= accept ? enc_err : ERR_NONE;
            done_q      <= (state_q == StDrain) && (state_d == StDone);
        end
    end

endmodule

// File: tb/tb_legv8_instr_writer.sv
// Scoreboard bench for legv8_instr_writer with a 4-word imem (ADDR_W=2).
module tb_legv8_instr_writer;
    import legv8_pkg::*;

    localparam int unsigned AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          finish = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [3:0]    req_op = '0;
    logic [4:0]    req_rd = '0, req_rn = '0, req_rm = '0;
    logic [31:0]   req_imm = '0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          imem_ready = 1'b1;
    logic          err_valid;
    logic [1:0]    err_code;
    logic          done;
    logic [AW:0]   word_count;

    int passed = 0;
    int total  = 0;

    logic [AW+31:0] exp_wr_q[$];
    logic [1:0]     exp_err_q[$];
    logic [AW-1:0]  exp_addr = '0;

    legv8_instr_writer #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .finish     (finish),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rd     (req_rd),
        .req_rn     (req_rn),
        .req_rm     (req_rm),
        .req_imm    (req_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_ready (imem_ready),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .done       (done),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes a write or flags an error.
    always @(negedge clk) begin
        logic [AW+31:0] e;
        logic [1:0]     ec;
        if (imem_we && imem_ready) begin
            if (exp_wr_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_write: addr %0d data 0x%08h, none required",
                         imem_addr, imem_wdata);
            end else begin
                e = exp_wr_q.pop_front();
                check("write_addr", 64'(imem_addr), 64'(e[AW+31:32]));
                check("write_data", 64'(imem_wdata), 64'(e[31:0]));
            end
        end
        if (err_valid) begin
            if (exp_err_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_error: err_code %0d, none required", err_code);
            end else begin
                ec = exp_err_q.pop_front();
                check("err_code", 64'(err_code), 64'(ec));
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                        input logic [4:0] rm, input logic [31:0] imm, input logic [1:0] err,
                        input logic [31:0] word);
        int n = 0;
        req_op = op; req_rd = rd; req_rn = rn; req_rm = rm; req_imm = imm;
        req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            total++;
            $display("FAIL accept_timeout: req_ready 0 after 50 cycles, required 1");
            req_valid = 1'b0;
            return;
        end
        if (err != ERR_NONE) begin
            exp_err_q.push_back(err);
        end else begin
            exp_wr_q.push_back({exp_addr, word});
            exp_addr++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_addr = '0;
    endtask

    task automatic finish_and_wait(input int exp_wc);
        logic got = 1'b0;
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check("done_pulse", 64'(got), 64'd1);
        if (got) begin
            check("done_word_count", 64'(word_count), 64'(exp_wc));
            @(negedge clk);
            check("done_one_cycle", 64'(done), 64'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic saw;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_imem_we", 64'(imem_we), 64'd0);
        check("rst_imem_addr", 64'(imem_addr), 64'd0);
        check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
        check("rst_err_valid", 64'(err_valid), 64'd0);
        check("rst_err_code", 64'(err_code), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_word_count", 64'(word_count), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Program 1: arithmetic, immediate-range error leaves the address unchanged.
        do_start();
        check("ready_in_run", 64'(req_ready), 64'd1);
        send(OpAdds, 5'd3, 5'd1, 5'd2, 32'd0, ERR_NONE, 32'hAB020023);
        send(OpAddi, 5'd5, 5'd0, 5'd0, 32'd4096, ERR_IMM_RANGE, 32'h0);
        send(OpSubs, 5'd3, 5'd1, 5'd2, 32'd0, ERR_NONE, 32'hEB020023);
        send(OpAddi, 5'd5, 5'd0, 5'd0, 32'd4095, ERR_NONE, 32'h913FFC05);
        send(OpLdur, 5'd2, 5'd7, 5'd0, -32'sd8, ERR_NONE, 32'hF85F80E2);
        finish_and_wait(4);

        // Program 2: branches, bad op, then stall at capacity.
        do_start();
        send(OpCbz, 5'd9, 5'd0, 5'd0, 32'd3, ERR_NONE, 32'hB4000069);
        send(OpBlt, 5'd0, 5'd0, 5'd0, -32'sd1, ERR_NONE, 32'h54FFFFEB);
        send(4'd15, 5'd0, 5'd0, 5'd0, 32'd0, ERR_BAD_OP, 32'h0);
        send(OpB, 5'd0, 5'd0, 5'd0, 32'd1, ERR_NONE, 32'h14000001);
        send(OpBl, 5'd0, 5'd0, 5'd0, -32'sd1, ERR_NONE, 32'h97FFFFFF);
        req_op = OpAdds; req_valid = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (req_ready) saw = 1'b1;
        end
        check("stall_at_capacity", 64'(saw), 64'd0);
        check("full_word_count", 64'(word_count), 64'd4);
        req_valid = 1'b0;
        finish_and_wait(4);

        // Program 3: memory back-pressure fills the FIFO; writes resume in order.
        imem_ready = 1'b0;
        do_start();
        send(OpAdds, 5'd3, 5'd1, 5'd2, 32'd0, ERR_NONE, 32'hAB020023);
        send(OpStur, 5'd1, 5'd2, 5'd0, 32'd255, ERR_NONE, 32'hF80FF041);
        req_op = OpBr; req_rn = 5'd30; req_valid = 1'b1;
        saw = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (req_ready) saw = 1'b1;
        end
        check("fifo_full_stall", 64'(saw), 64'd0);
        check("hold_we", 64'(imem_we), 64'd1);
        check("hold_addr", 64'(imem_addr), 64'd0);
        check("hold_data", 64'(imem_wdata), 64'hAB020023);
        imem_ready = 1'b1;
        send(OpBr, 5'd0, 5'd30, 5'd0, 32'd0, ERR_NONE, 32'hD61F03DE);
        finish_and_wait(3);

        // Program 4: reset during DRAIN discards queued words and returns to IDLE.
        imem_ready = 1'b0;
        do_start();
        send(OpAdds, 5'd1, 5'd2, 5'd3, 32'd0, ERR_NONE, 32'hAB030041);
        send(OpSubs, 5'd1, 5'd2, 5'd3, 32'd0, ERR_NONE, 32'hEB030041);
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
        rst_n = 1'b0;
        exp_wr_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        imem_ready = 1'b1;
        check("post_rst_we", 64'(imem_we), 64'd0);
        check("post_rst_word_count", 64'(word_count), 64'd0);
        check("post_rst_ready", 64'(req_ready), 64'd0);
        saw = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (imem_we) saw = 1'b1;
        end
        check("no_write_after_rst", 64'(saw), 64'd0);
        @(posedge clk); #1;
        finish = 1'b1; req_op = OpAdds; req_valid = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
        saw = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (req_ready) saw = 1'b1;
        end
        check("idle_ignores_finish", 64'(saw), 64'd0);
        req_valid = 1'b0;
        do_start();
        send(OpAdds, 5'd3, 5'd1, 5'd2, 32'd0, ERR_NONE, 32'hAB020023);
        finish_and_wait(1);

        repeat (3) @(posedge clk);
        check("write_queue_empty", 64'(exp_wr_q.size()), 64'd0);
        check("err_queue_empty", 64'(exp_err_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/legv8_instr_writer.md
# legv8_instr_writer

Streaming LEGv8 instruction encoder and program loader: the write-side counterpart of the control unit's instruction decode. Accepts symbolic instruction requests (op, registers, immediate) over a valid/ready handshake, encodes each into the 32-bit word the control unit decodes, and writes the words sequentially into instruction memory from word address 0. It is used by self-test and boot logic to build programs in imem without an external assembler.

## Interface

Parameters:
- ADDR_W, 10, imem word-address width; capacity is 2**ADDR_W words.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  begins a program; honored in IDLE/DONE only.
- finish  in  1  ends a program; honored in RUN only.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid&&ready at a clock edge.
- req_op  in  4  op_e: ADDS, SUBS, BR, LDUR, STUR, ADDI, CBZ, BLT, B, BL.
- req_rd, req_rn, req_rm  in  5 each  register fields (rd doubles as Rt).
- req_imm  in  32  signed immediate (branch offsets are in words).
- imem_we  out  1  write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- imem_ready  in  1  memory accepts the write this cycle.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  2  1 = bad op, 2 = immediate out of range.
- done  out  1  one-cycle pulse when the program is fully written.
- word_count  out  ADDR_W+1  number of words written this program.

## Operation

- States: IDLE, RUN, DRAIN, DONE. IDLE/DONE -> RUN on start, which clears the address counter and word_count. RUN -> DRAIN on finish. DRAIN -> DONE when the FIFO is empty. done pulses on entry to DONE.
- req_ready = (state==RUN) && FIFO not full && (word_count + FIFO occupancy < 2**ADDR_W). When capacity is reached, the block stalls. Stalling is not an error.
- A request accepted in the same cycle as finish is written before done.
- Encoding, with unlisted bits set to 0:
  - ADDS: 10101011000 in [31:21], Rm in [20:16], Rn in [9:5], Rd in [4:0].
  - SUBS: 11101011000 in [31:21], Rm, Rn, Rd as for ADDS.
  - BR: 11010110000 in [31:21], 11111 in [20:16], Rn in [9:5], and Rd = Rn in [4:0].
  - LDUR: 11111000010 in [31:21], imm9 in [20:12], Rn, Rt.
  - STUR: 11111000000 in [31:21], imm9 in [20:12], Rn, Rt.
  - ADDI: 1001000100 in [31:22], imm12 in [21:10], Rn, Rd.
  - CBZ: 10110100 in [31:24], imm19 in [23:5], Rt.
  - B.LT: 01010100 in [31:24], imm19 in [23:5], 01011 in [4:0].
  - B: 000101 in [31:26], imm26.
  - BL: 100101 in [31:26], imm26.
- Immediate ranges: imm9 signed −256..255; imm12 unsigned 0..4095; imm19 signed ±2^18; imm26 signed ±2^25. A value outside its range causes err_code=2.
- An illegal request (bad op or bad immediate) is still accepted. It is not written and does not advance the address. err_valid pulses in the cycle after acceptance.

## Timing

- Reset values: state IDLE. All outputs are 0: req_ready, imem_we, imem_addr, imem_wdata, err_valid, err_code, done, word_count. FIFO empty.
- Latency: a request accepted at edge N is presented to imem (imem_we=1) in cycle N+1 at the earliest.
- imem_we, imem_addr, and imem_wdata hold stable until imem_ready. Pop and address increment happen on the edge where imem_we && imem_ready.
- Push and pop may occur in the same cycle; occupancy is then unchanged.
- imem_addr is driven by the address counter and never wraps.
- When reset is asserted mid-operation, the FIFO is discarded, no further writes are issued, and the block returns to IDLE on the next edge.
- start and finish are ignored outside the states listed under Operation.

## Structure

- legv8_pkg: op_e enum, the 11/10/8/6-bit opcode constants, COND_LT = 5'b01011, imm range constants, and err_code localparams. Shared with control_unit.
- Sub-module legv8_instr_encode: combinational (op, regs, imm) -> {word, err_code}.
- The 2-entry FIFO and FSM are implemented inline.

## Test plan

- ADDS X3,X1,X2 -> addr 0, data 0xAB020023. SUBS X3,X1,X2 -> addr 1, data 0xEB020023.
- ADDI X5,X0,#4095 -> 0x913FFC05. ADDI with imm 4096 -> err_code=2, no write, next valid word still at addr 1.
- LDUR X2,[X7,#-8] -> 0xF85F80E2. CBZ X9,#3 -> 0xB4000069. B.LT #-1 -> 0x54FFFFEB.
- B #1 -> 0x14000001. BL #-1 -> 0x97FFFFFF. req_op=15 -> err_code=1.
- Hold imem_ready=0 while presenting 3 requests -> 2 accepted, then req_ready=0. Release -> writes occur in order at addr 0,1,2.
- ADDR_W=2: the 5th request stalls. finish -> done pulse with word_count=4. rst_n=0 during DRAIN -> no further imem_we, and state IDLE.
